// File: rtl/pingpong_fmap_ram_if.sv
// Producer/consumer port bundle for the ping-pong feature-map buffer.
interface pingpong_fmap_ram_if #(
    parameter int D_WIDTH = 15,
    parameter int A_WIDTH = 7
);
    logic               wr_en;
    logic [A_WIDTH-1:0] wr_addr;
    logic [D_WIDTH-1:0] wr_data;
    logic               wr_done;
    logic               wr_ready;
    logic               rd_en;
    logic [A_WIDTH-1:0] rd_addr;
    logic               rd_done;
    logic               rd_ready;
    logic [D_WIDTH-1:0] rd_data;
    logic               rd_valid;
    logic [1:0]         bank_full;
    logic               err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        input  wr_ready, rd_ready, rd_data, rd_valid, bank_full, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        output wr_ready, rd_ready, rd_data, rd_valid, bank_full, err
    );
endinterface

// File: rtl/pingpong_fmap_ram.sv
// Two-bank ping-pong feature-map buffer: producer fills one bank while the
// consumer drains the other; banks swap on commit/release.
module pingpong_fmap_ram #(
    parameter int D_WIDTH = 15,
    parameter int A_WIDTH = 7,
    parameter int DEPTH   = 2**A_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    pingpong_fmap_ram_if.slave bus
);
    localparam int              STAGES  = 1;
    localparam logic [A_WIDTH:0] DEPTH_W = (A_WIDTH+1)'(DEPTH);

    logic [D_WIDTH-1:0] mem [2][DEPTH];

    logic [1:0]         bank_full, full_nxt;
    logic               wr_bank, rd_bank;
    logic [D_WIDTH-1:0] rd_data;
    logic               err;
    logic [STAGES:0]    vld_pipe;

    logic wr_ready, rd_ready, wr_in_rng, rd_in_rng;
    logic wr_ok, rd_ok, wr_cmt, rd_rel, err_set;

    assign wr_ready  = ~bank_full[wr_bank];
    assign rd_ready  = bank_full[rd_bank];
    assign wr_in_rng = {1'b0, bus.wr_addr} < DEPTH_W;
    assign rd_in_rng = {1'b0, bus.rd_addr} < DEPTH_W;

    assign wr_ok  = bus.wr_en & wr_ready & wr_in_rng;
    assign rd_ok  = bus.rd_en & rd_ready & rd_in_rng;
    assign wr_cmt = bus.wr_done & wr_ready;
    assign rd_rel = bus.rd_done & rd_ready;

    assign err_set = ((bus.wr_en | bus.wr_done) & ~wr_ready) |
                     ((bus.rd_en | bus.rd_done) & ~rd_ready) |
                     (bus.wr_en & ~wr_in_rng) |
                     (bus.rd_en & ~rd_in_rng);

    // Commit and release can never hit the same bank, so both updates apply.
    always_comb begin
        full_nxt = bank_full;
        if (wr_cmt) full_nxt[wr_bank] = 1'b1;
        if (rd_rel) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_bank][bus.wr_addr] <= bus.wr_data;
    end

    assign vld_pipe[0] = rd_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bank_full          <= 2'b00;
            wr_bank            <= 1'b0;
            rd_bank            <= 1'b0;
            rd_data            <= '0;
            err                <= 1'b0;
            vld_pipe[STAGES:1] <= '0;
        end else begin
            bank_full          <= full_nxt;
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (wr_cmt)  wr_bank <= ~wr_bank;
            if (rd_rel)  rd_bank <= ~rd_bank;
            if (rd_ok)   rd_data <= mem[rd_bank][bus.rd_addr];
            if (err_set) err     <= 1'b1;
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.rd_ready  = rd_ready;
    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = vld_pipe[STAGES];
    assign bus.bank_full = bank_full;
    assign bus.err       = err;
endmodule

// File: tb/tb_pingpong_fmap_ram.sv
// Directed and random checks of the ping-pong buffer against a bank-level model.
module tb_pingpong_fmap_ram;
    localparam int DW = 15, AW = 7, DEPTH = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pingpong_fmap_ram_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();
    pingpong_fmap_ram #(.D_WIDTH(DW), .A_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    int errors = 0, checks = 0;

    // Reference model: two arrays of words plus per-bank status.
    logic [DW-1:0] m_mem   [2][DEPTH];
    bit            m_known [2][DEPTH];
    bit            m_full [2];
    int            m_wb, m_rb;
    bit            m_err, m_rvalid, m_dknown;
    logic [DW-1:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(!m_full[m_wb]));
        chk({tag, ".rd_ready"}, 32'(bus.rd_ready), 32'(m_full[m_rb]));
        chk({tag, ".bank_full"}, 32'(bus.bank_full), {30'b0, m_full[1], m_full[0]});
        chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_rvalid));
        if (m_dknown) chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(m_rdata));
    endtask

    task automatic idle_inputs();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_done = 0;
        bus.rd_en = 0; bus.rd_addr = '0; bus.rd_done = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        @(posedge clk);
        for (int b = 0; b < 2; b++) m_full[b] = 0;
        m_wb = 0; m_rb = 0; m_err = 0; m_rvalid = 0; m_rdata = '0; m_dknown = 1;
        #1 check_all(tag);
        reset = 1'b1;
    endtask

    // One clock: drive inputs, apply the operation rules to the model, check.
    task automatic cyc(input string tag, input bit wen, input int waddr, input int wdata,
                       input bit wdone, input bit ren, input int raddr, input bit rdone);
        bit wrdy, rrdy;
        bus.wr_en = wen; bus.wr_addr = AW'(waddr); bus.wr_data = DW'(wdata); bus.wr_done = wdone;
        bus.rd_en = ren; bus.rd_addr = AW'(raddr); bus.rd_done = rdone;
        @(posedge clk);
        wrdy = !m_full[m_wb];
        rrdy = m_full[m_rb];
        if ((wen || wdone) && !wrdy) m_err = 1;
        if ((ren || rdone) && !rrdy) m_err = 1;
        if (wen && waddr >= DEPTH) m_err = 1;
        if (ren && raddr >= DEPTH) m_err = 1;
        if (ren && rrdy && raddr < DEPTH) begin
            m_rvalid = 1; m_rdata = m_mem[m_rb][raddr]; m_dknown = m_known[m_rb][raddr];
        end else m_rvalid = 0;
        if (wen && wrdy && waddr < DEPTH) begin
            m_mem[m_wb][waddr] = DW'(wdata); m_known[m_wb][waddr] = 1;
        end
        if (rdone && rrdy) begin m_full[m_rb] = 0; m_rb ^= 1; end
        if (wdone && wrdy) begin m_full[m_wb] = 1; m_wb ^= 1; end
        #1 check_all(tag);
        idle_inputs();
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) m_known[b][a] = 0;
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        do_reset("reset");

        // Read while nothing is committed
        cyc("rd_at_reset", 0, 0, 0, 0, 1, 0, 0);
        chk("rd_at_reset.data0", 32'(bus.rd_data), 32'h0);
        do_reset("reset2");

        // Fill bank0 with 1..4, commit, read back
        for (int i = 0; i < 4; i++) cyc("wr_b0", 1, i, i + 1, 0, 0, 0, 0);
        cyc("commit_b0", 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("rd_b0", 0, 0, 0, 0, 1, i, 0);
        cyc("rd_b0_tail", 0, 0, 0, 0, 0, 0, 0);
        chk("b0.bank_full01", 32'(bus.bank_full), 32'h1);

        // Fill bank1 with 0x7FFF pattern plus last legal address; bad address ignored
        for (int i = 0; i < 4; i++) cyc("wr_b1", 1, i, 'h7FFF, 0, 0, 0, 0);
        cyc("wr_b1_99", 1, 99, 'h1234, 0, 0, 0, 0);
        cyc("wr_b1_100", 1, 100, 'h2222, 0, 0, 0, 0);
        chk("wr_100.err", 32'(bus.err), 32'h1);
        do_reset("reset3");
        for (int i = 0; i < 4; i++) cyc("wr_b0b", 1, i, 'h10 + i, 0, 0, 0, 0);
        cyc("commit_b0b", 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("wr_b1b", 1, i, 'h7FFF, 0, 0, 0, 0);
        cyc("wr_b1b_99", 1, 99, 'h1234, 0, 0, 0, 0);
        cyc("commit_b1b", 0, 0, 0, 1, 0, 0, 0);
        chk("both_full.wr_ready", 32'(bus.wr_ready), 32'h0);
        cyc("wr_when_full", 1, 0, 'h5555, 0, 0, 0, 0);
        chk("wr_when_full.err", 32'(bus.err), 32'h1);
        // Readback: last read of bank0 carries the release
        for (int i = 0; i < 4; i++) cyc("rb_b0", 0, 0, 0, 0, 1, i, i == 3);
        for (int i = 0; i < 4; i++) cyc("rb_b1", 0, 0, 0, 0, 1, i, 0);
        cyc("rb_b1_99", 0, 0, 0, 0, 1, 99, 0);
        cyc("rb_tail", 0, 0, 0, 0, 0, 0, 0);
        chk("rb_b1_99.data", 32'(bus.rd_data), 32'h1234);

        // Simultaneous commit of bank1 and release of bank0
        do_reset("reset4");
        for (int i = 0; i < 3; i++) cyc("sim_w0", 1, i, 'h20 + i, 0, 0, 0, 0);
        cyc("sim_c0", 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("sim_w1", 1, i, 'h30 + i, 0, 0, 0, 0);
        cyc("sim_swap", 0, 0, 0, 1, 0, 0, 1);
        chk("sim_swap.bank_full10", 32'(bus.bank_full), 32'h2);
        chk("sim_swap.err0", 32'(bus.err), 32'h0);
        for (int i = 0; i < 3; i++) cyc("sim_rd1", 0, 0, 0, 0, 1, i, 0);
        cyc("sim_tail", 0, 0, 0, 0, 0, 0, 0);

        // Reset with both banks full and a read in flight
        cyc("rst_fill0", 1, 5, 'h44, 1, 0, 0, 0);
        chk("rst_fill.both_full", 32'(bus.bank_full), 32'h3);
        cyc("rst_rd", 0, 0, 0, 0, 1, 0, 0);
        bus.rd_en = 1;
        do_reset("rst_inflight");
        idle_inputs();
        chk("rst_inflight.bank_full00", 32'(bus.bank_full), 32'h0);

        // Random traffic, with occasional resets
        for (int n = 0; n < 600; n++) begin
            bit wen, wdone, ren, rdone;
            int waddr, raddr;
            if (n % 150 == 149) begin
                do_reset("rnd_reset");
                continue;
            end
            wen   = !m_full[m_wb] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
            ren   =  m_full[m_rb] ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 31) == 0);
            waddr = ($urandom_range(0, 19) == 0) ? $urandom_range(DEPTH, 127) : $urandom_range(0, 15);
            raddr = ($urandom_range(0, 19) == 0) ? $urandom_range(DEPTH, 127) : $urandom_range(0, 15);
            wdone = ($urandom_range(0, 9) == 0);
            rdone = ($urandom_range(0, 9) == 0);
            cyc("rnd", wen, waddr, int'($urandom_range(0, 32767)), wdone, ren, raddr, rdone);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
